// File: rtl/mul_pkg.sv
// Shared widths and types for the integer multiply unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

   localparam int MUL_W       = 32;
   localparam int PROD_W      = 64;
   localparam int MUL_LATENCY = 4;

   typedef logic [MUL_W-1:0]  word_t;
   typedef logic [PROD_W-1:0] dword_t;

endpackage : mul_pkg

// File: rtl/mul_pp17x16.sv
// Partial-product multiplier: signed 17-bit x unsigned 16-bit -> signed 33-bit.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   i_a  17-bit two's-complement operand
//   i_b  16-bit unsigned operand (treated as zero-extended to 17 bits)
//   o_p  33-bit two's-complement product (always exact: |a*b| < 2^32)
module mul_pp17x16 (
   input  logic [16:0] i_a,
   input  logic [15:0] i_b,
   output logic [32:0] o_p
);

   logic signed [32:0] w_a;
   logic signed [32:0] w_b;

   assign w_a = {{16{i_a[16]}}, i_a};
   assign w_b = {17'd0, i_b};
   assign o_p = w_a * w_b;

endmodule : mul_pp17x16

// File: rtl/mul32.sv
// Fully pipelined 32x32 -> 64 multiplier, signed or unsigned per operation.
// Latency: 4 clock edges from operand sample to dest; one new op per cycle.
// Backpressure: none; the pipeline advances every cycle, consumers track validity by latency.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, clears every stage including dest
//   is_signed  1 = both operands two's-complement, 0 = both unsigned
//   src        multiplicand
//   sink       multiplier
//   dest       registered 64-bit product
module mul32
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        is_signed,
   input  logic [31:0] src,
   input  logic [31:0] sink,
   output logic [63:0] dest
);

   // 33-bit extension makes signed and unsigned operands one signed case:
   // bit 32 is the sign only when is_signed, otherwise a zero.
   logic [32:0] w_a_ext;
   logic [32:0] w_b_ext;

   assign w_a_ext = {is_signed & src[31],  src};
   assign w_b_ext = {is_signed & sink[31], sink};

   // S1: extended operands
   logic [32:0] r_a;
   logic [32:0] r_b;

   // Operand split: x = x_hi * 2^16 + x_lo, x_hi = x[32:16] signed, x_lo unsigned.
   // hi*hi would need a 17x17 multiplier, so it is taken as a_hi * b[31:16]
   // minus a_hi * 2^16 when b's sign bit is set (b[32] has weight -2^32).
   logic [32:0] w_p_hh;
   logic [32:0] w_p_hl;
   logic [32:0] w_p_lh;
   logic [32:0] w_p_ll;
   logic [16:0] w_corr;

   mul_pp17x16 u_pp_hh (.i_a(r_a[32:16]),         .i_b(r_b[31:16]), .o_p(w_p_hh));
   mul_pp17x16 u_pp_hl (.i_a(r_a[32:16]),         .i_b(r_b[15:0]),  .o_p(w_p_hl));
   mul_pp17x16 u_pp_lh (.i_a(r_b[32:16]),         .i_b(r_a[15:0]),  .o_p(w_p_lh));
   mul_pp17x16 u_pp_ll (.i_a({1'b0, r_a[15:0]}),  .i_b(r_b[15:0]),  .o_p(w_p_ll));

   assign w_corr = r_b[32] ? r_a[32:16] : 17'd0;

   // S2: partial products
   logic [32:0] r_p_hh;
   logic [32:0] r_p_hl;
   logic [32:0] r_p_lh;
   logic [32:0] r_p_ll;
   logic [16:0] r_corr;

   // Reduction to two terms; everything is modulo 2^64 so sign-extend then shift.
   logic [33:0] w_mid;
   dword_t      w_t_hi;
   dword_t      w_t_lo;

   assign w_mid  = {r_p_hl[32], r_p_hl} + {r_p_lh[32], r_p_lh};
   assign w_t_hi = ({{31{r_p_hh[32]}}, r_p_hh} << 32)
                 - ({{47{r_corr[16]}}, r_corr} << 48);
   assign w_t_lo = ({{30{w_mid[33]}}, w_mid} << 16)
                 + {31'd0, r_p_ll};

   // S3: two-term sum
   dword_t r_t_hi;
   dword_t r_t_lo;

   // S4: product
   dword_t r_dest;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_p_hh <= '0;
         r_p_hl <= '0;
         r_p_lh <= '0;
         r_p_ll <= '0;
         r_corr <= '0;
         r_t_hi <= '0;
         r_t_lo <= '0;
         r_dest <= '0;
      end else begin
         r_a    <= w_a_ext;
         r_b    <= w_b_ext;
         r_p_hh <= w_p_hh;
         r_p_hl <= w_p_hl;
         r_p_lh <= w_p_lh;
         r_p_ll <= w_p_ll;
         r_corr <= w_corr;
         r_t_hi <= w_t_hi;
         r_t_lo <= w_t_lo;
         r_dest <= r_t_hi + r_t_lo;
      end
   end

   assign dest = r_dest;

endmodule : mul32

// File: tb/tb_mul32.sv
// Self-checking bench for mul32: directed corner products, reset flush, random stream.
// Latency: checks each product exactly MUL_LATENCY-1 edges after the sampling edge.
// Backpressure: none exercised; the DUT has no handshake.
module tb_mul32;
   import mul_pkg::*;

   logic   clk;
   logic   rst;
   logic   is_signed;
   word_t  src;
   word_t  sink;
   dword_t dest;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   // Expected dest for the op sampled at each edge; zeroed when reset discards it.
   dword_t hist_exp [0:2047];
   string  hist_tag [0:2047];

   mul32 u_dut (
      .clk       (clk),
      .rst       (rst),
      .is_signed (is_signed),
      .src       (src),
      .sink      (sink),
      .dest      (dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input dword_t got, input dword_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Arithmetic reference from the plain definition of the product.
   function automatic dword_t ref_mul(input logic s, input word_t a, input word_t b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = s ? {{32{a[31]}}, a} : {32'd0, a};
      sb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return dword_t'(sa * sb);
   endfunction

   // Apply one op for one edge, then check what must emerge after that edge.
   task automatic step(input logic r, input logic s, input word_t a, input word_t b,
                       input dword_t exp, input string tag);
      dword_t want;
      string  wtag;
      rst       = r;
      is_signed = s;
      src       = a;
      sink      = b;
      @(posedge clk);
      hist_exp[edge_n] = r ? 64'd0 : exp;
      hist_tag[edge_n] = r ? "reset_edge" : tag;
      if (r) begin
         for (int j = 1; j < MUL_LATENCY; j++) begin
            if (edge_n - j >= 0) begin
               hist_exp[edge_n - j] = 64'd0;
               hist_tag[edge_n - j] = "flushed";
            end
         end
      end
      @(negedge clk);
      if (edge_n >= MUL_LATENCY - 1) begin
         want = hist_exp[edge_n - (MUL_LATENCY - 1)];
         wtag = hist_tag[edge_n - (MUL_LATENCY - 1)];
      end else begin
         want = 64'd0;
         wtag = "post_reset_fill";
      end
      check(wtag, dest, want);
      edge_n++;
   endtask

   initial begin
      word_t a;
      word_t b;
      logic  s;

      rst = 1'b1; is_signed = 1'b0; src = '0; sink = '0;

      // Reset with live-looking operands, which must be ignored.
      step(1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 64'd0, "rst0");
      step(1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0, "rst1");
      check("reset_dest", dest, 64'd0);

      // Directed corner products, issued back to back.
      step(1'b0, 1'b1, 32'h00000001, 32'h0000FFFF, 64'h000000000000FFFF, "s_small");
      step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "s_m1xm1");
      step(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "u_maxxmax");
      step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF, "s_m1x1");
      step(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, "u_maxx1");
      step(1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, "s_minxmin");
      step(1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, "s_minxmax");
      step(1'b0, 1'b1, 32'h00000000, 32'h12345678, 64'h0000000000000000, "s_zero");
      step(1'b0, 1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000, "u_zero");
      step(1'b0, 1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, "u_2p16sq");
      step(1'b0, 1'b1, 32'hFFFF0000, 32'h00010000, 64'hFFFFFFFF00000000, "s_neg2p16");
      step(1'b0, 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, "u_2p31sq");

      // Reset mid-stream: three ops in flight must never surface.
      step(1'b0, 1'b0, 32'h00000003, 32'h00000005, 64'd15, "inflight0");
      step(1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000007, 64'hFFFFFFFFFFFFFFF2, "inflight1");
      step(1'b0, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, "inflight2");
      step(1'b1, 1'b1, 32'h55555555, 32'hAAAAAAAA, 64'd0, "rst_mid");
      step(1'b0, 1'b0, 32'h00020000, 32'h00030000, 64'h0000000600000000, "after_rst");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 32'h0, 32'h0, 64'd0, "idle");

      // Random stream, is_signed toggling every cycle.
      for (int i = 0; i < 1000; i++) begin
         s = i[0];
         a = $urandom;
         b = $urandom;
         if (i % 17 == 0) a = 32'h80000000;
         if (i % 23 == 0) b = 32'hFFFFFFFF;
         step(1'b0, s, a, b, ref_mul(s, a, b), s ? "rand_s" : "rand_u");
      end

      // Drain the pipeline.
      for (int i = 0; i < MUL_LATENCY; i++)
         step(1'b0, 1'b0, 32'h0, 32'h0, 64'd0, "drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mul32
